// File: rtl/branch_pkg.sv
// Shared op encodings and default widths for the branch/jump execute unit.
package branch_pkg;

  localparam int unsigned OP_W              = 3;
  localparam int unsigned XLEN_DEFAULT      = 64;
  localparam int unsigned RAS_DEPTH_DEFAULT = 8;

  typedef enum logic [OP_W-1:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JR   = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; oldest entry is overwritten when full.
module branch_ras #(
  parameter int unsigned Xlen  = 64,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [Xlen-1:0] push_data_i,
  output logic [Xlen-1:0] top_o,
  output logic [CntW-1:0] count_o
);

  logic [Xlen-1:0] mem_q [Depth];
  logic [PtrW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_ok;

  // ptr_q points at the next free slot; the top lives one below it.
  assign top_idx = ptr_q - PtrW'(1);
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;
  assign pop_ok  = pop_i & (count_q != '0);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_idx  = ptr_q;
    if (push_i && pop_ok) begin
      wr_idx = top_idx;
    end else if (push_i) begin
      ptr_d = ptr_q + PtrW'(1);
      if (count_q != CntW'(Depth)) count_d = count_q + CntW'(1);
    end else if (pop_ok) begin
      ptr_d   = top_idx;
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (push_i) mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/ex_branch_ras.sv
// Branch/jump execute unit: compare, target adder, registered result with
// commit-stall hold, misaligned-target fault and return-address prediction.
module ex_branch_ras
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT,
  parameter int unsigned IMM_SHIFT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_enable_i,
  output logic            ex_busy_o,
  input  logic [OP_W-1:0] op_i,
  input  logic            link_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            stall_i,
  output logic            res_valid_o,
  output logic            do_jump_o,
  output logic [XLEN-1:0] jump_pc_o,
  output logic [XLEN-1:0] r63_o,
  output logic            r63_update_o,
  output logic            misalign_o,
  output logic            ras_hit_o
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  br_op_e          op;
  logic            accept, hold, taken, good, is_jr, push, pop, hit;
  logic [XLEN-1:0] target, ras_top;
  logic [CntW-1:0] ras_count;

  logic            res_valid_q, res_valid_d, do_jump_q, do_jump_d;
  logic            r63_update_q, r63_update_d, misalign_q, misalign_d;
  logic            ras_hit_q, ras_hit_d;
  logic [XLEN-1:0] jump_pc_q, jump_pc_d, r63_q, r63_d;

  assign op        = br_op_e'(op_i);
  assign hold      = res_valid_q & stall_i;
  assign ex_busy_o = hold;
  assign accept    = ex_enable_i & ~hold;
  assign is_jr     = (op == BR_JR);

  always_comb begin
    unique case (op)
      BR_BEQ:  taken = (in1_i == in2_i);
      BR_BNE:  taken = (in1_i != in2_i);
      BR_BLT:  taken = ($signed(in1_i) < $signed(in2_i));
      BR_BGE:  taken = ($signed(in1_i) >= $signed(in2_i));
      BR_BLTU: taken = (in1_i < in2_i);
      BR_BGEU: taken = (in1_i >= in2_i);
      BR_JR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign target = is_jr ? in1_i : next_pc_i + (imm_i << IMM_SHIFT);
  assign good   = taken & ~target[0];
  // Faulting or not-taken ops leave the stack alone.
  assign push   = accept & good & link_i;
  assign pop    = accept & good & is_jr & (ras_count != '0);
  assign hit    = pop & (ras_top == in1_i);

  branch_ras #(
    .Xlen  (XLEN),
    .Depth (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (next_pc_i),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );

  always_comb begin
    res_valid_d  = 1'b0;
    do_jump_d    = 1'b0;
    jump_pc_d    = '0;
    r63_d        = '0;
    r63_update_d = 1'b0;
    misalign_d   = 1'b0;
    ras_hit_d    = 1'b0;
    if (hold) begin
      res_valid_d  = res_valid_q;
      do_jump_d    = do_jump_q;
      jump_pc_d    = jump_pc_q;
      r63_d        = r63_q;
      r63_update_d = r63_update_q;
      misalign_d   = misalign_q;
      ras_hit_d    = ras_hit_q;
    end else if (accept) begin
      res_valid_d  = 1'b1;
      do_jump_d    = good;
      jump_pc_d    = good ? target : '0;
      r63_d        = (good & link_i) ? next_pc_i : '0;
      r63_update_d = good & link_i;
      misalign_d   = taken & target[0];
      ras_hit_d    = hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q  <= 1'b0;
      do_jump_q    <= 1'b0;
      jump_pc_q    <= '0;
      r63_q        <= '0;
      r63_update_q <= 1'b0;
      misalign_q   <= 1'b0;
      ras_hit_q    <= 1'b0;
    end else begin
      res_valid_q  <= res_valid_d;
      do_jump_q    <= do_jump_d;
      jump_pc_q    <= jump_pc_d;
      r63_q        <= r63_d;
      r63_update_q <= r63_update_d;
      misalign_q   <= misalign_d;
      ras_hit_q    <= ras_hit_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign do_jump_o    = do_jump_q;
  assign jump_pc_o    = jump_pc_q;
  assign r63_o        = r63_q;
  assign r63_update_o = r63_update_q;
  assign misalign_o   = misalign_q;
  assign ras_hit_o    = ras_hit_q;

endmodule

// File: tb/tb_ex_branch_ras.sv
// Directed bench for ex_branch_ras: compares, wrap, stall hold, RAS and reset.
module tb_ex_branch_ras;

  logic        clk = 1'b0;
  logic        rst, ex_enable, ex_busy, link, stall;
  logic [2:0]  op;
  logic [63:0] in1, in2, imm, next_pc;
  logic        res_valid, do_jump, r63_update, misalign, ras_hit;
  logic [63:0] jump_pc, r63;

  int n_checks = 0;
  int n_fail   = 0;

  ex_branch_ras #(
    .XLEN      (64),
    .RAS_DEPTH (8),
    .IMM_SHIFT (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ex_enable_i  (ex_enable),
    .ex_busy_o    (ex_busy),
    .op_i         (op),
    .link_i       (link),
    .in1_i        (in1),
    .in2_i        (in2),
    .imm_i        (imm),
    .next_pc_i    (next_pc),
    .stall_i      (stall),
    .res_valid_o  (res_valid),
    .do_jump_o    (do_jump),
    .jump_pc_o    (jump_pc),
    .r63_o        (r63),
    .r63_update_o (r63_update),
    .misalign_o   (misalign),
    .ras_hit_o    (ras_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks every registered output against an expected result.
  task automatic chk_out(input string tag, input logic rv, input logic dj,
                         input logic [63:0] jpc, input logic [63:0] lr, input logic upd,
                         input logic mis, input logic hit);
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(rv));
    chk({tag, ".do_jump"}, 64'(do_jump), 64'(dj));
    chk({tag, ".jump_pc"}, jump_pc, jpc);
    chk({tag, ".r63"}, r63, lr);
    chk({tag, ".r63_update"}, 64'(r63_update), 64'(upd));
    chk({tag, ".misalign"}, 64'(misalign), 64'(mis));
    chk({tag, ".ras_hit"}, 64'(ras_hit), 64'(hit));
  endtask

  task automatic drive(input logic en, input logic [2:0] o, input logic lk,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] im, input logic [63:0] npc);
    ex_enable = en; op = o; link = lk; in1 = a; in2 = b; imm = im; next_pc = npc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    step(); step();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.busy", 64'(ex_busy), 64'd0);
    rst = 1'b0;

    // BEQ taken, then one-cycle pulse clears.
    drive(1'b1, 3'd0, 1'b0, 64'd5, 64'd5, 64'd4, 64'h100);
    step();
    chk_out("beq", 1, 1, 64'h108, 0, 0, 0, 0);
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    step();
    chk_out("idle", 0, 0, 0, 0, 0, 0, 0);

    // Signed vs unsigned compares on -1 / 1.
    drive(1'b1, 3'd2, 1'b0, '1, 64'd1, 64'h10, 64'h300);
    step();
    chk_out("blt", 1, 1, 64'h320, 0, 0, 0, 0);
    drive(1'b1, 3'd4, 1'b0, '1, 64'd1, 64'h10, 64'h300);
    step();
    chk_out("bltu", 1, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 3'd5, 1'b0, '1, 64'd1, 64'h10, 64'h300);
    step();
    chk_out("bgeu", 1, 1, 64'h320, 0, 0, 0, 0);
    drive(1'b1, 3'd3, 1'b0, '1, 64'd1, 64'h10, 64'h300);
    step();
    chk_out("bge", 1, 0, 0, 0, 0, 0, 0);

    // BNE+link then a three-cycle stall with enable asserted (must be ignored).
    drive(1'b1, 3'd1, 1'b1, 64'd1, 64'd2, 64'h20, 64'h200);
    step();
    stall = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 64'd7, 64'd7, 64'd0, 64'h500);
    #1 chk("stall.busy", 64'(ex_busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1, 1, 64'h240, 64'h200, 1, 0, 0);
      chk("stall.busy_hold", 64'(ex_busy), 64'd1);
    end
    stall = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    #1 chk("release.busy", 64'(ex_busy), 64'd0);
    step();
    chk_out("release", 0, 0, 0, 0, 0, 0, 0);
    // Return matches the pushed link address; the dropped op pushed nothing.
    drive(1'b1, 3'd6, 1'b0, 64'h200, 64'd0, 64'd0, 64'h900);
    step();
    chk_out("jr_hit", 1, 1, 64'h200, 0, 0, 0, 1);
    drive(1'b1, 3'd6, 1'b0, 64'h500, 64'd0, 64'd0, 64'h900);
    step();
    chk_out("jr_empty", 1, 1, 64'h500, 0, 0, 0, 0);

    // Nine linked calls into an 8-deep stack, then nine returns.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 3'd0, 1'b1, 64'd0, 64'd0, 64'd0, 64'h1000 + 64'(i) * 64'h10);
      step();
      chk("push.r63", r63, 64'h1000 + 64'(i) * 64'h10);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'd6, 1'b0, 64'h1080 - 64'(k) * 64'h10, 64'd0, 64'd0, 64'h2000);
      step();
      chk("pop.ras_hit", 64'(ras_hit), 64'd1);
    end
    drive(1'b1, 3'd6, 1'b0, 64'h1000, 64'd0, 64'd0, 64'h2000);
    step();
    chk_out("pop9", 1, 1, 64'h1000, 0, 0, 0, 0);

    // JR+link replaces the top with the new return address.
    drive(1'b1, 3'd0, 1'b1, 64'd0, 64'd0, 64'd0, 64'hA0);
    step();
    drive(1'b1, 3'd6, 1'b1, 64'hA0, 64'd0, 64'd0, 64'hB0);
    step();
    chk_out("jrl", 1, 1, 64'hA0, 64'hB0, 1, 0, 1);
    drive(1'b1, 3'd6, 1'b0, 64'hB0, 64'd0, 64'd0, 64'h0);
    step();
    chk("jrl.pop_new", 64'(ras_hit), 64'd1);
    drive(1'b1, 3'd6, 1'b0, 64'hA0, 64'd0, 64'd0, 64'h0);
    step();
    chk("jrl.empty", 64'(ras_hit), 64'd0);

    // Target wrap, misaligned JR (no push), reserved op.
    drive(1'b1, 3'd0, 1'b0, 64'd3, 64'd3, 64'd8, 64'hFFFF_FFFF_FFFF_FFF0);
    step();
    chk_out("wrap", 1, 1, 64'h0, 0, 0, 0, 0);
    drive(1'b1, 3'd6, 1'b1, 64'h101, 64'd0, 64'd0, 64'h300);
    step();
    chk_out("misalign", 1, 0, 0, 0, 0, 1, 0);
    drive(1'b1, 3'd6, 1'b0, 64'h300, 64'd0, 64'd0, 64'h0);
    step();
    chk_out("misalign.nopush", 1, 1, 64'h300, 0, 0, 0, 0);
    drive(1'b1, 3'd7, 1'b1, 64'd1, 64'd1, 64'd0, 64'h400);
    step();
    chk_out("rsvd", 1, 0, 0, 0, 0, 0, 0);

    // Reset while holding a stalled result.
    drive(1'b1, 3'd0, 1'b1, 64'd0, 64'd0, 64'd0, 64'h40);
    step();
    stall = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    step();
    chk("prerst.busy", 64'(ex_busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("rst_stall", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall.busy", 64'(ex_busy), 64'd0);
    stall = 1'b0;
    drive(1'b1, 3'd6, 1'b0, 64'h40, 64'd0, 64'd0, 64'd0);
    step();
    chk_out("rst_stall.ras_empty", 1, 1, 64'h40, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
